imem_loader: RTL and testbench

Byte-serial program loader that writes the Y86-64 instruction memory: the writer side of the byte-wide instruction store that the fetch stage reads in 10-byte windows. It accepts a framed byte stream over a valid/ready handshake, writes payload bytes into the 1024-byte instruction memory, and checks each segment's bounds and checksum. On a terminator frame it releases the processor with an entry PC. It replaces hard-coded `initial` program images with a loadable path.

---
 rtl/imem_loader_if.sv | 28 ++
 rtl/imem_loader.sv | 156 +++++++++++++++
 tb/tb_imem_loader.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Stream-in handshake plus instruction-memory write port and loader status.
interface imem_loader_if;
  localparam int unsigned AW = 10;
  localparam int unsigned CW = 11;

  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          cpu_run;
  logic [63:0]   entry_pc;
  logic          load_err;
  logic [CW-1:0] byte_count;

  // Stream source / memory + processor side
  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, cpu_run, entry_pc, load_err, byte_count
  );

  // Loader side
  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, cpu_run, entry_pc, load_err, byte_count
  );
endinterface

// File: rtl/imem_loader.sv
// Byte-serial framed program loader for the Y86-64 instruction memory.
module imem_loader (
  input logic         clk,
  input logic         rst_n,
  imem_loader_if.slave bus
);
  localparam int unsigned MEM_BYTES = 1024;
  localparam int unsigned AW        = 10;
  localparam int unsigned LW        = AW + 1;
  localparam int unsigned CW        = 11;
  localparam int unsigned SW        = 17;

  typedef enum logic [2:0] {
    S_AH, S_AL, S_LH, S_LL, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    len_hi_q, len_hi_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] ptr_q, ptr_d;
  logic [7:0]    csum_q, csum_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          cpu_run_q, cpu_run_d;
  logic [AW-1:0] entry_q, entry_d;
  logic          load_err_q, load_err_d;
  logic [CW-1:0] byte_count_q, byte_count_d;

  logic          in_ready_c;
  logic          accept_c;
  logic [15:0]   len_full_c;
  logic [SW-1:0] end_c;

  // Ready is gated by reset so the source sees 0 while rst_n is low.
  assign in_ready_c = rst_n && (state_q != S_DONE) && (state_q != S_ERR);
  assign accept_c   = bus.in_valid && in_ready_c;
  assign len_full_c = {len_hi_q, bus.in_data};
  assign end_c      = SW'(addr_q) + SW'(len_full_c);

  // Frame parser: next state, write strobe, checksum and status updates.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_hi_d     = len_hi_q;
    len_d        = len_q;
    ptr_d        = ptr_q;
    csum_d       = csum_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    cpu_run_d    = cpu_run_q;
    entry_d      = entry_q;
    load_err_d   = load_err_q;
    byte_count_d = byte_count_q;

    if (accept_c) begin
      case (state_q)
        S_AH: begin
          if (bus.in_data[7:2] != 6'd0) begin
            state_d    = S_ERR;
            load_err_d = 1'b1;
          end else begin
            addr_d  = {bus.in_data[1:0], 8'h00};
            state_d = S_AL;
          end
        end
        S_AL: begin
          addr_d  = {addr_q[AW-1:8], bus.in_data};
          state_d = S_LH;
        end
        S_LH: begin
          len_hi_d = bus.in_data;
          state_d  = S_LL;
        end
        S_LL: begin
          csum_d = 8'h00;
          ptr_d  = '0;
          if (len_full_c == 16'd0) begin
            state_d   = S_DONE;
            cpu_run_d = 1'b1;
            entry_d   = addr_q;
          end else if (end_c > SW'(MEM_BYTES)) begin
            // Also covers LEN > MEM_BYTES since addr is non-negative.
            state_d    = S_ERR;
            load_err_d = 1'b1;
          end else begin
            len_d   = LW'(len_full_c);
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q + ptr_q[AW-1:0];
          wr_data_d = bus.in_data;
          csum_d    = csum_q ^ bus.in_data;
          ptr_d     = ptr_q + LW'(1);
          if (byte_count_q != {CW{1'b1}}) byte_count_d = byte_count_q + CW'(1);
          if (ptr_q + LW'(1) == len_q) state_d = S_CSUM;
        end
        S_CSUM: begin
          if (bus.in_data == csum_q) begin
            state_d = S_AH;
          end else begin
            state_d    = S_ERR;
            load_err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State and registered outputs; async reset drops any pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_AH;
      addr_q       <= '0;
      len_hi_q     <= '0;
      len_q        <= '0;
      ptr_q        <= '0;
      csum_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      cpu_run_q    <= 1'b0;
      entry_q      <= '0;
      load_err_q   <= 1'b0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_hi_q     <= len_hi_d;
      len_q        <= len_d;
      ptr_q        <= ptr_d;
      csum_q       <= csum_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      cpu_run_q    <= cpu_run_d;
      entry_q      <= entry_d;
      load_err_q   <= load_err_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.cpu_run    = cpu_run_q;
  assign bus.entry_pc   = 64'(entry_q);
  assign bus.load_err   = load_err_q;
  assign bus.byte_count = byte_count_q;
endmodule

// File: tb/tb_imem_loader.sv
// Randomized frame-stream bench for imem_loader with a frame-level reference model.
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imem_loader_if bus();
  imem_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  bit [7:0] mem     [1024];
  bit [7:0] mem_exp [1024];
  int       wr_cnt = 0;

  // Instruction memory as seen by the fetch stage.
  always @(posedge clk) begin
    if (bus.wr_en === 1'b1) begin
      mem[bus.wr_addr] <= bus.wr_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  bit [7:0] stim[$];
  int exp_cons, exp_pay, exp_pc, got_cons, base_wr, cur_run, max_run;
  bit exp_run, exp_err;

  // Reference: walk the stream frame by frame and apply the loading rules.
  task automatic model_run(input int n);
    int i, a, l;
    bit [7:0] x;
    i = 0; exp_pay = 0; exp_run = 0; exp_err = 0; exp_pc = 0;
    while (i < n) begin
      if (int'(stim[i]) > 3) begin exp_err = 1; i++; break; end
      if (i + 4 > n) begin i = n; break; end
      a = int'(stim[i]) * 256 + int'(stim[i+1]);
      l = int'(stim[i+2]) * 256 + int'(stim[i+3]);
      i += 4;
      if (l == 0) begin exp_run = 1; exp_pc = a; break; end
      if (a + l > 1024) begin exp_err = 1; break; end
      x = 8'h00;
      for (int j = 0; j < l && i < n; j++) begin
        mem_exp[10'(a + j)] = stim[i];
        x ^= stim[i];
        exp_pay++;
        i++;
      end
      if (i >= n) break;
      if (stim[i] != x) begin exp_err = 1; i++; break; end
      i++;
    end
    exp_cons = i;
  endtask

  task automatic add_hdr(input int a, input int l);
    stim.push_back(8'(a >> 8)); stim.push_back(8'(a));
    stim.push_back(8'(l >> 8)); stim.push_back(8'(l));
  endtask

  task automatic add_seg(input int a, input int l, input bit bad);
    bit [7:0] b, x;
    x = 8'h00;
    add_hdr(a, l);
    for (int j = 0; j < l; j++) begin
      b = 8'($urandom);
      stim.push_back(b);
      x ^= b;
    end
    stim.push_back(bad ? (x ^ 8'h5A) : x);
  endtask

  task automatic track_run();
    if (bus.wr_en === 1'b1) begin
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
    end else cur_run = 0;
  endtask

  // Drive stim with random valid gaps; give up once ready stays low.
  task automatic send(input int gap_pct, input int limit);
    int idle;
    bit done, acc;
    got_cons = 0; idle = 0; done = 0;
    for (int i = 0; i < stim.size() && i < limit && !done; i++) begin
      acc = 0;
      while (!acc && !done) begin
        @(negedge clk);
        track_run();
        if (int'($urandom_range(99)) < gap_pct) begin
          bus.in_valid = 1'b0;
          bus.in_data  = 8'($urandom);
        end else begin
          bus.in_valid = 1'b1;
          bus.in_data  = stim[i];
          if (bus.in_ready !== 1'b1) begin
            idle++;
            if (idle > 3) done = 1;
          end else begin
            idle = 0;
            @(posedge clk);
            #1;
            acc = 1;
            got_cons++;
          end
        end
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic finish_check(input string tag);
    int mm;
    chk({tag, ".accepted"}, 64'(got_cons), 64'(exp_cons));
    chk({tag, ".load_err"}, 64'(bus.load_err), 64'(exp_err));
    chk({tag, ".cpu_run"}, 64'(bus.cpu_run), 64'(exp_run));
    chk({tag, ".entry_pc"}, bus.entry_pc, 64'(exp_pc));
    chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(!(exp_run || exp_err)));
    chk({tag, ".byte_count"}, 64'(bus.byte_count), 64'((exp_pay > 2047) ? 2047 : exp_pay));
    repeat (2) begin @(negedge clk); track_run(); end
    chk({tag, ".writes"}, 64'(wr_cnt - base_wr), 64'(exp_pay));
    mm = 0;
    for (int k = 0; k < 1024; k++) if (mem[k] != mem_exp[k]) mm++;
    chk({tag, ".mem_diffs"}, 64'(mm), 64'(0));
  endtask

  task automatic run_test(input string tag, input int gap_pct);
    model_run(stim.size());
    send(gap_pct, stim.size());
    finish_check(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base_wr = wr_cnt; cur_run = 0; max_run = 0;
    stim.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int a, l;
    bit [7:0] v;
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst.in_ready", 64'(bus.in_ready), 64'(0));
    chk("rst.wr_en", 64'(bus.wr_en), 64'(0));
    chk("rst.wr_addr", 64'(bus.wr_addr), 64'(0));
    chk("rst.wr_data", 64'(bus.wr_data), 64'(0));
    chk("rst.cpu_run", 64'(bus.cpu_run), 64'(0));
    chk("rst.entry_pc", bus.entry_pc, 64'(0));
    chk("rst.load_err", 64'(bus.load_err), 64'(0));
    chk("rst.byte_count", 64'(bus.byte_count), 64'(0));
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rst.ready_rise", 64'(bus.in_ready), 64'(1));
    base_wr = wr_cnt; cur_run = 0; max_run = 0;

    // Two-byte segment and terminator at 0
    stim = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h10, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_test("basic", 0);
    chk("basic.mem0", 64'(mem[0]), 64'h10);
    chk("basic.mem1", 64'(mem[1]), 64'h10);

    // 95-byte program, entry at 0x038
    do_reset();
    begin
      bit [7:0] x;
      x = 8'h00;
      add_hdr(0, 95);
      for (int j = 0; j < 95; j++) begin
        v = (j == 56) ? 8'hA0 : (j == 57) ? 8'h9F : 8'($urandom);
        stim.push_back(v);
        x ^= v;
      end
      stim.push_back(x);
      add_hdr(16'h0038, 0);
    end
    run_test("prog95", 25);
    chk("prog95.fetch56", 64'(mem[56]), 64'hA0);
    chk("prog95.fetch57", 64'(mem[57]), 64'h9F);
    chk("prog95.entry", bus.entry_pc, 64'd56);

    // Bad checksum, trailing terminator must be ignored
    do_reset();
    add_hdr(16'h0200, 2);
    stim.push_back(8'h30); stim.push_back(8'hF2); stim.push_back(8'h00);
    add_hdr(0, 0);
    run_test("badcsum", 0);

    // Bounds: last byte legal, one past illegal, ADDR_HI out of range
    do_reset();
    add_seg(16'h03FF, 1, 0);
    add_hdr(16'h0010, 0);
    run_test("bnd_ok", 0);
    do_reset();
    add_seg(16'h03FF, 2, 0);
    add_hdr(0, 0);
    run_test("bnd_over", 0);
    do_reset();
    add_seg(16'h0400, 1, 0);
    run_test("bnd_ahi", 0);

    // Continuous stream: one write per cycle
    do_reset();
    add_seg(16'h0080, 50, 0);
    add_hdr(16'h0080, 0);
    run_test("stream", 0);
    chk("stream.max_run", 64'(max_run), 64'd50);

    // Random multi-segment loads with gaps and injected errors
    for (int it = 0; it < 6; it++) begin
      do_reset();
      for (int s = 0; s < int'($urandom_range(1, 4)); s++) begin
        a = int'($urandom_range(0, 1023));
        l = int'($urandom_range(1, ((1024 - a) < 48) ? (1024 - a) : 48));
        if ($urandom_range(7) == 0) l = 1025 - a + int'($urandom_range(0, 3));
        add_seg(a, l, $urandom_range(9) == 0);
      end
      a = int'($urandom_range(0, 1023));
      if ($urandom_range(7) == 0) a = 16'h0400 + int'($urandom_range(0, 255));
      add_hdr(a, 0);
      run_test($sformatf("rand%0d", it), 30);
    end

    // Reset mid-payload: pending write is dropped, fresh load restarts counters
    do_reset();
    add_hdr(16'h0100, 10);
    for (int j = 0; j < 10; j++) stim.push_back((j == 4) ? ~mem_exp[10'h104] : 8'($urandom));
    stim.push_back(8'h00);
    model_run(8);
    send(0, 9);
    chk("midrst.pending", 64'(bus.wr_en), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst.in_ready", 64'(bus.in_ready), 64'(0));
    chk("midrst.wr_en", 64'(bus.wr_en), 64'(0));
    chk("midrst.wr_addr", 64'(bus.wr_addr), 64'(0));
    chk("midrst.wr_data", 64'(bus.wr_data), 64'(0));
    chk("midrst.byte_count", 64'(bus.byte_count), 64'(0));
    chk("midrst.load_err", 64'(bus.load_err), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    base_wr = wr_cnt; cur_run = 0; max_run = 0;
    stim.delete();
    add_seg(16'h0300, 8, 0);
    add_hdr(16'h0300, 0);
    run_test("midrst", 20);

    // byte_count saturation across 3 full-memory segments
    do_reset();
    for (int s = 0; s < 3; s++) add_seg(0, 1024, 0);
    add_hdr(16'h0004, 0);
    run_test("sat", 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
